// File: rtl/csel_adder_pkg.sv
// Shared types, derived-size helpers and legality checks for the pipelined carry-select adder.
package csel_adder_pkg;

    localparam int unsigned CSEL_MAX_W = 64;

    // Beat payload carried between stages: operand bits still to be summed, sum bits already done,
    // the carry out of the last evaluated block and the subtract flag of the beat.
    typedef struct packed {
        logic [CSEL_MAX_W-1:0] a;
        logic [CSEL_MAX_W-1:0] b;
        logic [CSEL_MAX_W-1:0] sum;
        logic                  carry;
        logic                  sub;
    } csel_payload_t;

    function automatic int num_blocks(input int width, input int block);
        return width / block;
    endfunction

    function automatic int stages(input int width, input int block, input int bps);
        return num_blocks(width, block) / bps;
    endfunction

    function automatic bit params_legal(input int width, input int block, input int bps);
        if (width <= 0 || block <= 0 || bps <= 0 || width > int'(CSEL_MAX_W)) begin
            return 1'b0;
        end else begin
            return ((width % block) == 0) && ((num_blocks(width, block) % bps) == 0);
        end
    endfunction

endpackage

// File: rtl/csel_adder_block.sv
// One carry-select block: two ripple-carry adders (carry-in 0 and 1) and the select mux.
module csel_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0]   c0_s;
    logic [BLOCK:0]   c1_s;
    logic [BLOCK-1:0] s0_s;
    logic [BLOCK-1:0] s1_s;

    // Both ripple chains, evaluated speculatively before the incoming carry is known
    always_comb begin
        c0_s    = '0;
        c1_s    = '0;
        s0_s    = '0;
        s1_s    = '0;
        c1_s[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            s0_s[i]   = a[i] ^ b[i] ^ c0_s[i];
            c0_s[i+1] = (a[i] & b[i]) | (c0_s[i] & (a[i] ^ b[i]));
            s1_s[i]   = a[i] ^ b[i] ^ c1_s[i];
            c1_s[i+1] = (a[i] & b[i]) | (c1_s[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = cin ? s1_s : s0_s;
    assign cout = cin ? c1_s[BLOCK] : c0_s[BLOCK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Elastic pipelined carry-select adder/subtractor with valid/ready on both sides.
// Define CSEL_ADDER_SAT_EN to saturate out_sum to the signed limits on overflow.
module pipelined_csel_adder
    import csel_adder_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int BLOCK            = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = stages(WIDTH, BLOCK, BLOCKS_PER_STAGE);
    localparam int BPS    = BLOCKS_PER_STAGE;
    localparam int SW     = BPS * BLOCK;

    if (!params_legal(WIDTH, BLOCK, BLOCKS_PER_STAGE)) begin : g_bad_params
        $error("pipelined_csel_adder: illegal WIDTH/BLOCK/BLOCKS_PER_STAGE combination");
    end

    csel_payload_t              accept_s;
    csel_payload_t              src_s   [STAGES];
    csel_payload_t              nxt_s   [STAGES];
    csel_payload_t              stage_r [STAGES];
    logic [STAGES-1:0]          valid_r;
    logic [STAGES-1:0]          src_valid_s;
    logic [STAGES-1:0]          stage_cout_s;
    logic [STAGES:0]            load_s;
    logic [STAGES-1:0][SW-1:0]  blk_sum_s;
    logic [WIDTH-1:0]           sum_s;
    logic                       ovf_s;

    // Subtraction becomes A + ~B + 1 at the point of acceptance
    always_comb begin
        accept_s                = '0;
        accept_s.a[WIDTH-1:0]   = in_a;
        accept_s.sub            = in_sub;
        if (in_sub) begin
            accept_s.b[WIDTH-1:0] = ~in_b;
            accept_s.carry        = 1'b1;
        end else begin
            accept_s.b[WIDTH-1:0] = in_b;
            accept_s.carry        = in_cin;
        end
    end

    // A stage loads when empty or when the stage after it is moving on
    always_comb begin
        load_s         = '0;
        load_s[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load_s[k] = ~valid_r[k] | load_s[k+1];
        end
    end

    assign in_ready = load_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src_in
            assign src_s[k]       = accept_s;
            assign src_valid_s[k] = in_valid;
        end else begin : g_src_prev
            assign src_s[k]       = stage_r[k-1];
            assign src_valid_s[k] = valid_r[k-1];
        end

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            localparam int LSB = (k * BPS + j) * BLOCK;
            logic cin_s;
            logic cout_s;

            if (j == 0) begin : g_cin_stage
                assign cin_s = src_s[k].carry;
            end else begin : g_cin_chain
                assign cin_s = g_blk[j-1].cout_s;
            end

            csel_block #(.BLOCK(BLOCK)) u_blk (
                .a    (src_s[k].a[LSB +: BLOCK]),
                .b    (src_s[k].b[LSB +: BLOCK]),
                .cin  (cin_s),
                .sum  (blk_sum_s[k][j*BLOCK +: BLOCK]),
                .cout (cout_s)
            );
        end

        assign stage_cout_s[k] = g_blk[BPS-1].cout_s;
    end

    // Each stage fills in its own slice of sum bits and replaces the running carry
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k]                    = src_s[k];
            nxt_s[k].sum[k*SW +: SW]    = blk_sum_s[k];
            nxt_s[k].carry              = stage_cout_s[k];
        end
    end

    // Stage registers; payload only moves with a real beat so held data is never disturbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                    if (src_valid_s[k]) begin
                        stage_r[k] <= nxt_s[k];
                    end
                end
            end
        end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit
    assign ovf_s = stage_r[STAGES-1].a[WIDTH-1] ^ stage_r[STAGES-1].b[WIDTH-1]
                 ^ stage_r[STAGES-1].sum[WIDTH-1] ^ stage_r[STAGES-1].carry;

`ifdef CSEL_ADDER_SAT_EN
    // On overflow both operands share a sign; that sign picks the saturation limit
    always_comb begin
        if (ovf_s) begin
            if (stage_r[STAGES-1].a[WIDTH-1]) begin
                sum_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                sum_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            sum_s = stage_r[STAGES-1].sum[WIDTH-1:0];
        end
    end
`else
    assign sum_s = stage_r[STAGES-1].sum[WIDTH-1:0];
`endif

    assign out_valid = valid_r[STAGES-1];
    assign out_sum   = sum_s;
    assign out_cout  = stage_r[STAGES-1].carry;
    assign out_ovf   = ovf_s;

endmodule
